// File: rtl/wgt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wgt_pkg
// Purpose  : Shared definitions for the weight-address generator:
//            FSM state encoding, counter-width helper and the
//            words-per-filter helper.
// Ports    : none (package)
// Options  : WGT_ADDR_REPEAT_EN (used by wgt_addr_gen, not here)
// Revision : 1.0 - initial release
// ============================================================================
package wgt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter spanning 0..n-1, never narrower than one bit so
   // that degenerate dimensions (n == 1) still produce a legal vector.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Number of weight words making up one filter.
   function automatic int words_per_filter(input int kernel_size, input int no_channel);
      return no_channel * kernel_size * kernel_size;
   endfunction

   localparam int DEF_KERNEL_SIZE  = 3;
   localparam int DEF_NO_CHANNEL   = 3;
   localparam int WORDS_PER_FILTER = words_per_filter(DEF_KERNEL_SIZE, DEF_NO_CHANNEL);

endpackage
`default_nettype wire

// File: rtl/wgt_nest_cnt.sv
`default_nettype none
// ============================================================================
// Module   : wgt_nest_cnt
// Purpose  : Cascaded wrap counter kx -> ky -> c -> f. kx advances on every
//            enabled cycle; each outer counter advances when all inner ones
//            wrap. The filter counter wraps at a runtime limit (last_f).
// Ports    : clk, rst_n   clock, asynchronous active-low reset
//            clear        synchronous clear of all counters
//            en           advance by one position
//            last_f       index of the final filter (num_filter-1)
//            kx, ky, c, f current position
//            last         current position is the final word of the block
// Revision : 1.0 - initial release
// ============================================================================
module wgt_nest_cnt
   import wgt_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int NO_CHANNEL  = 3,
   parameter int NO_FILTER   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clear,
   input  logic                                 en,
   input  logic [clog2_min1(NO_FILTER)-1:0]     last_f,
   output logic [clog2_min1(KERNEL_SIZE)-1:0]   kx,
   output logic [clog2_min1(KERNEL_SIZE)-1:0]   ky,
   output logic [clog2_min1(NO_CHANNEL)-1:0]    c,
   output logic [clog2_min1(NO_FILTER)-1:0]     f,
   output logic                                 last
);

   localparam int KW = clog2_min1(KERNEL_SIZE);
   localparam int CW = clog2_min1(NO_CHANNEL);

   localparam logic [KW-1:0] K_MAX = KW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0] C_MAX = CW'(NO_CHANNEL - 1);

   logic kx_wrap;
   logic ky_wrap;
   logic c_wrap;

   // Carry chain: each stage wraps only when every inner stage wraps too.
   always_comb begin
      kx_wrap = (kx == K_MAX);
      ky_wrap = kx_wrap && (ky == K_MAX);
      c_wrap  = ky_wrap && (c == C_MAX);
      last    = c_wrap && (f == last_f);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kx <= '0;
         ky <= '0;
         c  <= '0;
         f  <= '0;
      end else if (clear) begin
         kx <= '0;
         ky <= '0;
         c  <= '0;
         f  <= '0;
      end else if (en) begin
         kx <= kx_wrap ? '0 : kx + 1'b1;
         if (kx_wrap) begin
            ky <= (ky == K_MAX) ? '0 : ky + 1'b1;
         end
         if (ky_wrap) begin
            c <= (c == C_MAX) ? '0 : c + 1'b1;
         end
         if (c_wrap) begin
            f <= (f == last_f) ? '0 : f + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wgt_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : wgt_addr_gen
// Purpose  : Weight-address generator for the systolic-array weight buffer.
//            On load, walks num_filter x NO_CHANNEL x KERNEL_SIZE^2 words
//            from a runtime base address with ready/valid backpressure,
//            then pulses done for one cycle.
// Ports    : clk, rst_n    clock, asynchronous active-low reset
//            load          start pulse, honoured only in IDLE
//            base_addr     first address, latched on load
//            num_filter    filters to walk (0 or >NO_FILTER -> NO_FILTER)
//            repeat_cnt    extra passes, latched on load (option only)
//            addr_ready    consumer accepts wgt_addr
//            wgt_addr      registered weight address
//            addr_valid    wgt_addr valid (RUN)
//            busy          high in RUN
//            done          one-cycle pulse after the final handshake
// Options  : WGT_ADDR_REPEAT_EN - adds repeat_cnt; sequence is emitted
//            repeat_cnt+1 times back-to-back before done.
// Revision : 1.0 - initial release
// ============================================================================
module wgt_addr_gen
   import wgt_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int NO_CHANNEL  = 3,
   parameter int NO_FILTER   = 16,
   parameter int ADDR_WIDTH  = 11
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [$clog2(NO_FILTER+1)-1:0]   num_filter,
`ifdef WGT_ADDR_REPEAT_EN
   input  logic [7:0]                       repeat_cnt,
`endif
   input  logic                             addr_ready,
   output logic [ADDR_WIDTH-1:0]            wgt_addr,
   output logic                             addr_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int NFW = $clog2(NO_FILTER + 1);
   localparam int FW  = clog2_min1(NO_FILTER);
   localparam int KW  = clog2_min1(KERNEL_SIZE);
   localparam int CW  = clog2_min1(NO_CHANNEL);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] offset_q;
   logic [FW-1:0]         last_f_q;
   logic [NFW-1:0]        nf_eff;
   logic [FW-1:0]         last_f_load;
   logic                  start;
   logic                  xfer;
   logic                  last;
   logic                  final_pass;

   logic [KW-1:0]         cnt_kx;
   logic [KW-1:0]         cnt_ky;
   logic [CW-1:0]         cnt_c;
   logic [FW-1:0]         cnt_f;

   // --------------------------------------------------------------------
   // Command decode
   // --------------------------------------------------------------------
   always_comb begin
      if ((num_filter == '0) || (num_filter > NFW'(NO_FILTER))) begin
         nf_eff = NFW'(NO_FILTER);
      end else begin
         nf_eff = num_filter;
      end
      last_f_load = FW'(nf_eff - NFW'(1));
   end

   assign start = (state_q == IDLE) && load;
   assign xfer  = (state_q == RUN) && addr_ready;

   // --------------------------------------------------------------------
   // Pass counter (remaining extra passes)
   // --------------------------------------------------------------------
`ifdef WGT_ADDR_REPEAT_EN
   logic [7:0] pass_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q <= '0;
      end else if (start) begin
         pass_q <= repeat_cnt;
      end else if (xfer && last && (pass_q != '0)) begin
         pass_q <= pass_q - 8'd1;
      end
   end

   assign final_pass = (pass_q == '0);
`else
   assign final_pass = 1'b1;
`endif

   // --------------------------------------------------------------------
   // Position counters; they wrap to zero on the last word so a following
   // pass starts cleanly without an extra clear cycle.
   // --------------------------------------------------------------------
   wgt_nest_cnt #(
      .KERNEL_SIZE (KERNEL_SIZE),
      .NO_CHANNEL  (NO_CHANNEL),
      .NO_FILTER   (NO_FILTER)
   ) u_nest_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start),
      .en     (xfer),
      .last_f (last_f_q),
      .kx     (cnt_kx),
      .ky     (cnt_ky),
      .c      (cnt_c),
      .f      (cnt_f),
      .last   (last)
   );

   // Position counters are kept for waveform debug only.
   logic unused_dbg;
   assign unused_dbg = ^{cnt_kx, cnt_ky, cnt_c, cnt_f};

   // --------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = RUN;
            end
         end
         RUN: begin
            addr_valid = 1'b1;
            busy       = 1'b1;
            if (xfer && last && final_pass) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------
   // Address datapath. The offset advances by one per transfer; the output
   // register is loaded with base+next_offset so wgt_addr only moves on a
   // handshake and wraps modulo 2^ADDR_WIDTH naturally.
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         offset_q <= '0;
         last_f_q <= '0;
         wgt_addr <= '0;
      end else if (start) begin
         base_q   <= base_addr;
         offset_q <= '0;
         last_f_q <= last_f_load;
         wgt_addr <= base_addr;
      end else if (xfer) begin
         if (last) begin
            offset_q <= '0;
            wgt_addr <= base_q;
         end else begin
            offset_q <= offset_q + 1'b1;
            wgt_addr <= base_q + offset_q + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
